plugboard_loader: RTL and testbench

Configuration writer for the Enigma plugboard: turns operator letter selections into validated, symmetric swap pairs and writes them into the plugboard substitution table over a valid/ready write port. It sits between the keyboard front end and the plugboard table. It ensures that:
- a letter is never plugged twice;
- self-pairs are never written;
- no more than MAX_PAIRS pairs are ever written;
- every pair is written in both directions (A→B, then B→A).

---
 rtl/plugboard_loader_if.sv | 25 ++
 rtl/plugboard_loader.sv | 121 ++++++++++++
 tb/tb_plugboard_loader.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/plugboard_loader_if.sv
// Keyboard-side selection inputs, plugboard-table write port and loader status.
// master = the loader, slave = the keyboard front end / table side.
interface plugboard_loader_if;
    logic        key_valid;
    logic [25:0] key_letter;
    logic        clear;
    logic        wr_valid;
    logic        wr_ready;
    logic        wr_clear;
    logic [25:0] wr_in;
    logic [25:0] wr_out;
    logic [25:0] used;
    logic [3:0]  pair_count;
    logic        busy;
    logic        err;

    modport master (
        input  key_valid, key_letter, clear, wr_ready,
        output wr_valid, wr_clear, wr_in, wr_out, used, pair_count, busy, err
    );
    modport slave (
        output key_valid, key_letter, clear, wr_ready,
        input  wr_valid, wr_clear, wr_in, wr_out, used, pair_count, busy, err
    );
endinterface

// File: rtl/plugboard_loader.sv
// Turns letter selections into symmetric plugboard swap pairs and writes them
// (forward then reverse) into the plugboard table; also issues table clears.
module plugboard_loader #(
    parameter int MAX_PAIRS = 10
) (
    input logic              CLOCK_50,
    input logic              reset,
    plugboard_loader_if.master bus
);
    typedef enum logic [2:0] {IDLE, FIRST, WRITE_FWD, WRITE_REV, CLEAR} state_t;

    state_t      state;
    logic [25:0] a, b;
    logic        clear_pending;

    logic        letter_ok, letter_used, full, xfer;

    assign letter_ok   = (bus.key_letter != '0) &&
                         ((bus.key_letter & (bus.key_letter - 26'd1)) == '0);
    assign letter_used = |(bus.key_letter & bus.used);
    assign full        = bus.pair_count >= 4'(MAX_PAIRS);
    assign xfer        = bus.wr_valid & bus.wr_ready;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            a              <= '0;
            b              <= '0;
            clear_pending  <= 1'b0;
            bus.wr_valid   <= 1'b0;
            bus.wr_clear   <= 1'b0;
            bus.wr_in      <= '0;
            bus.wr_out     <= '0;
            bus.used       <= '0;
            bus.pair_count <= '0;
            bus.busy       <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            bus.err <= 1'b0;
            case (state)
                IDLE, FIRST: begin
                    // clear beats a coincident key; the key is dropped silently
                    if (bus.clear) begin
                        state        <= CLEAR;
                        a            <= '0;
                        bus.wr_valid <= 1'b1;
                        bus.wr_clear <= 1'b1;
                        bus.wr_in    <= '0;
                        bus.wr_out   <= '0;
                        bus.busy     <= 1'b1;
                    end else if (bus.key_valid) begin
                        if (!letter_ok) begin
                            bus.err <= 1'b1;
                        end else if (state == IDLE) begin
                            if (letter_used || full) begin
                                bus.err <= 1'b1;
                            end else begin
                                a     <= bus.key_letter;
                                state <= FIRST;
                            end
                        end else if (bus.key_letter == a) begin
                            state <= IDLE;
                        end else if (letter_used) begin
                            bus.err <= 1'b1;
                        end else begin
                            b            <= bus.key_letter;
                            state        <= WRITE_FWD;
                            bus.wr_valid <= 1'b1;
                            bus.wr_clear <= 1'b0;
                            bus.wr_in    <= a;
                            bus.wr_out   <= bus.key_letter;
                            bus.busy     <= 1'b1;
                        end
                    end
                end
                WRITE_FWD: begin
                    if (bus.clear) clear_pending <= 1'b1;
                    if (xfer) begin
                        state      <= WRITE_REV;
                        bus.wr_in  <= b;
                        bus.wr_out <= a;
                    end
                end
                WRITE_REV: begin
                    if (xfer) begin
                        bus.used <= bus.used | a | b;
                        if (!full) bus.pair_count <= bus.pair_count + 4'd1;
                        // a clear seen during the pair goes out right after it commits
                        if (clear_pending || bus.clear) begin
                            state         <= CLEAR;
                            clear_pending <= 1'b0;
                            bus.wr_clear  <= 1'b1;
                            bus.wr_in     <= '0;
                            bus.wr_out    <= '0;
                        end else begin
                            state        <= IDLE;
                            bus.wr_valid <= 1'b0;
                            bus.busy     <= 1'b0;
                        end
                    end else if (bus.clear) begin
                        clear_pending <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (xfer) begin
                        state          <= IDLE;
                        a              <= '0;
                        b              <= '0;
                        clear_pending  <= 1'b0;
                        bus.used       <= '0;
                        bus.pair_count <= '0;
                        bus.wr_valid   <= 1'b0;
                        bus.wr_clear   <= 1'b0;
                        bus.busy       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_plugboard_loader.sv
// Randomized bench for plugboard_loader: a set-based plugboard model predicts
// table writes and err pulses into queues; a negedge monitor pops and compares.
module tb_plugboard_loader;
    localparam int MAXP = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    plugboard_loader_if bus();

    plugboard_loader #(.MAX_PAIRS(MAXP)) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        clr;
        logic [25:0] src;
        logic [25:0] dst;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_err[$];
    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  rdy_mode = 1;   // 0 = hold low, 1 = hold high, 2 = random

    bit  m_used[26];
    int  m_pairs;
    int  m_first;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    always @(posedge clk) cyc++;

    initial begin
        bus.wr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       bus.wr_ready = 1'b0;
                1:       bus.wr_ready = 1'b1;
                default: bus.wr_ready = 1'($urandom % 2);
            endcase
        end
    end

    // ---------------- monitor ----------------
    wr_t stall_pl;
    bit  stalled = 1'b0;

    always @(negedge clk) begin
        wr_t cur;
        wr_t e;
        if (!rst) begin
            cur = {bus.wr_clear, bus.wr_in, bus.wr_out};
            if (stalled) begin
                chk("hold_valid", 64'(bus.wr_valid), 64'd1);
                chk("hold_payload", 64'(cur), 64'(stall_pl));
            end
            if (bus.wr_valid && bus.wr_ready) begin
                if (exp_wr.size() == 0) begin
                    note_fail("unexpected_write");
                end else begin
                    e = exp_wr.pop_front();
                    chk("write", 64'(cur), 64'(e));
                end
            end
            stalled  = bus.wr_valid && !bus.wr_ready;
            stall_pl = cur;
            if (exp_err.size() > 0 && exp_err[0] == cyc) begin
                void'(exp_err.pop_front());
                chk("err_pulse", 64'(bus.err), 64'd1);
            end else if (bus.err) begin
                chk("err_spurious", 64'(bus.err), 64'd0);
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [25:0] m_vec();
        logic [25:0] v = '0;
        for (int i = 0; i < 26; i++) v[i] = m_used[i];
        return v;
    endfunction

    function automatic int idx_of(input logic [25:0] l);
        for (int i = 0; i < 26; i++) if (l[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 26; i++) m_used[i] = 1'b0;
        m_pairs = 0;
        m_first = -1;
    endtask

    task automatic model_key(input logic [25:0] l, output bit wrote);
        int i;
        logic [25:0] f;
        wrote = 1'b0;
        if ($countones(l) != 1) begin
            exp_err.push_back(cyc + 1);
        end else begin
            i = idx_of(l);
            if (m_first < 0) begin
                if (m_used[i] || m_pairs == MAXP) exp_err.push_back(cyc + 1);
                else m_first = i;
            end else if (i == m_first) begin
                m_first = -1;
            end else if (m_used[i]) begin
                exp_err.push_back(cyc + 1);
            end else begin
                f = 26'd1 << m_first;
                exp_wr.push_back({1'b0, f, l});
                exp_wr.push_back({1'b0, l, f});
                m_used[i] = 1'b1;
                m_used[m_first] = 1'b1;
                m_pairs++;
                m_first = -1;
                wrote = 1'b1;
            end
        end
    endtask

    task automatic model_clear();
        exp_wr.push_back({1'b1, 26'd0, 26'd0});
        model_reset();
    endtask

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [25:0] l, input bit kv, input bit clr);
        bus.key_valid  = kv;
        bus.key_letter = l;
        bus.clear      = clr;
        step();
        bus.key_valid = 1'b0;
        bus.clear     = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_wr.size() > 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (exp_wr.size() > 0) begin
            note_fail("drain_timeout");
            exp_wr.delete();
        end
        if (n > 0) #1;
    endtask

    task automatic do_key(input logic [25:0] l);
        bit w;
        model_key(l, w);
        pulse(l, 1'b1, 1'b0);
        if (w) drain();
    endtask

    task automatic do_clear(input bit with_key);
        model_clear();
        pulse(26'd1 << ($urandom % 26), with_key, 1'b1);
        drain();
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_used"}, 64'(bus.used), 64'(m_vec()));
        chk({tag, "_pairs"}, 64'(bus.pair_count), 64'(m_pairs));
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_wr_valid"}, 64'(bus.wr_valid), 64'd0);
    endtask

    function automatic logic [25:0] bad_letter();
        int x = $urandom % 26;
        int y = (x + 1 + ($urandom % 25)) % 26;
        case ($urandom % 3)
            0:       return 26'd0;
            1:       return (26'd1 << x) | (26'd1 << y);
            default: return 26'h3ffffff;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit w;
        bus.key_valid  = 1'b0;
        bus.key_letter = '0;
        bus.clear      = 1'b0;
        model_reset();

        #12;
        chk("rst_wr_valid", 64'(bus.wr_valid), 64'd0);
        chk("rst_wr_clear", 64'(bus.wr_clear), 64'd0);
        chk("rst_payload", 64'({bus.wr_in, bus.wr_out}), 64'd0);
        chk("rst_used", 64'(bus.used), 64'd0);
        chk("rst_pairs", 64'(bus.pair_count), 64'd0);
        chk("rst_busy_err", 64'({bus.busy, bus.err}), 64'd0);
        step();
        rst = 1'b0;
        step();

        // A<->B with exact latency
        do_key(26'h1);
        model_key(26'h2, w);
        pulse(26'h2, 1'b1, 1'b0);
        chk("fwd_valid", 64'(bus.wr_valid), 64'd1);
        chk("fwd_payload", 64'({bus.wr_in, bus.wr_out}), 64'({26'h1, 26'h2}));
        step();
        chk("rev_payload", 64'({bus.wr_in, bus.wr_out}), 64'({26'h2, 26'h1}));
        step();
        chk("commit_used", 64'(bus.used), 64'h3);
        chk("commit_pairs", 64'(bus.pair_count), 64'd1);
        chk("commit_busy", 64'(bus.busy), 64'd0);
        chk("commit_queue", 64'(exp_wr.size()), 64'd0);

        // reuse rejected while holding C, then C<->D
        do_key(26'h4);
        do_key(26'h1);
        check_status("reuse");
        do_key(26'h8);
        check_status("pair_cd");

        // cancel and invalid letters
        do_key(26'h10);
        do_key(26'h10);
        do_key(26'h3);
        do_key(26'h0);
        check_status("cancel");

        // capacity
        do_clear(1'b0);
        for (int i = 0; i < MAXP; i++) begin
            do_key(26'd1 << (2 * i));
            do_key(26'd1 << (2 * i + 1));
        end
        do_key(26'd1 << 24);
        check_status("capacity");

        // clear together with a key: clear wins, no err
        do_clear(1'b1);
        check_status("key_clear");

        // backpressure with keys and a clear during the stall
        rdy_mode = 0;
        step();
        do_key(26'h4);
        model_key(26'h8, w);
        pulse(26'h8, 1'b1, 1'b0);
        pulse(26'h20, 1'b1, 1'b0);
        model_clear();
        pulse(26'h0, 1'b0, 1'b1);
        pulse(26'h40, 1'b1, 1'b0);
        step();
        rdy_mode = 1;
        drain();
        check_status("backpressure");

        // async reset while the reverse write is stalled
        rdy_mode = 0;
        step();
        do_key(26'h100);
        model_key(26'h200, w);
        pulse(26'h200, 1'b1, 1'b0);
        rdy_mode = 1;
        step();
        rdy_mode = 0;
        #2;
        chk("pre_rst_rev", 64'({bus.wr_valid, bus.wr_in, bus.wr_out}), 64'({1'b1, 26'h200, 26'h100}));
        rst = 1'b1;
        #1;
        chk("arst_wr_valid", 64'(bus.wr_valid), 64'd0);
        chk("arst_status", 64'({bus.busy, bus.used, bus.pair_count}), 64'd0);
        rst = 1'b0;
        exp_wr.delete();
        model_reset();
        rdy_mode = 1;
        step();
        do_key(26'h400);
        do_key(26'h800);
        check_status("after_rst");

        // randomized traffic with random backpressure
        rdy_mode = 2;
        do_clear(1'b0);
        for (int n = 0; n < 400; n++) begin
            int r = $urandom % 20;
            if (r == 0) do_clear(1'($urandom % 2));
            else if (r < 3) do_key(bad_letter());
            else do_key(26'd1 << ($urandom % 26));
            check_status("rand");
        end

        rdy_mode = 1;
        repeat (3) step();
        chk("leftover_writes", 64'(exp_wr.size()), 64'd0);
        chk("leftover_errs", 64'(exp_err.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
